playback_sequencer: RTL and testbench
=====================================

# playback_sequencer

Reads back the notes stored by the note-recording datapath and turns them into sound. On `start` it steps `note_counter` from 0 to `last_index` and holds `ld_play` high so the datapath addresses its note memory. It waits for the registered memory read and frequency lookup to settle, then latches `freq_in` and drives a square wave on `audio_out` for a fixed note time. A silent gap follows each note. It stops after the last note, or repeats when `loop` is high.

## Interface
Parameters:
- `NOTE_TICKS`, 25_000_000: clk cycles a note sounds (≥2).
- `GAP_TICKS`, 2_500_000: clk cycles of silence after each note (≥1).
- `SETTLE_CYCLES`, 3: cycles from `note_counter` change to `freq_in` valid. Covers the datapath address register plus the memory output register. Must be ≥3.

Ports:
- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin playback.
- `stop` in 1: single-cycle request to abort playback.
- `loop` in 1: level; when high, wrap to note 0 after `last_index`.
- `last_index` in 4: index of last recorded note (0–15); sampled on accepted `start`.
- `freq_in` in 32: half-period of the tone in clk cycles, from the frequency lookup. 0 = rest.
- `ld_play` out 1: high while not IDLE; selects playback addressing in the datapath.
- `note_counter` out 4: note address presented to the datapath.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `audio_out` out 1: square-wave tone output.

## Operation
- The state machine has four states: IDLE, SETTLE, SOUND and GAP.
- Reset (async, `reset`=0) forces the following, at any time including mid-note:
  - state IDLE
  - `note_counter`=0, `ld_play`=0, `busy`=0, `done`=0, `audio_out`=0
  - all counters 0
  - latched `last_index` = 0
- IDLE:
  - `start`=1 → SETTLE. On that edge: `note_counter`←0, latch `last_index`, settle counter←0.
  - `stop` is ignored in IDLE.
- SETTLE:
  - Counts `SETTLE_CYCLES` cycles.
  - On the last one: latch `freq_in` into `period`, clear the tone counter and note counter, set `audio_out`←0, then go to SOUND.
- SOUND:
  - The note counter runs for `NOTE_TICKS` cycles.
  - Tone generator: if `period`=0, `audio_out` stays 0. Otherwise the tone counter counts 0..`period`−1; on reaching `period`−1 it clears and toggles `audio_out`.
  - When the note counter reaches `NOTE_TICKS`−1: go to GAP, set `audio_out`←0, clear the gap counter.
- GAP:
  - `audio_out`=0 for `GAP_TICKS` cycles. On the last cycle:
  - If `note_counter` < latched index: `note_counter`+1 → SETTLE.
  - Else if `loop`=1: `note_counter`←0 → SETTLE.
  - Else → IDLE with `done`=1 for exactly one cycle, and `note_counter`←0.
- `stop`=1 in any non-IDLE state → IDLE next edge:
  - `audio_out`←0, `note_counter`←0, `done` stays 0.
  - `stop` has priority over any same-cycle transition.
- `start` while busy is ignored, so playback cannot restart mid-sequence.
- `start` and `stop` asserted in the same IDLE cycle: `start` wins, because `stop` is ignored in IDLE.
- `freq_in` is sampled only at the end of SETTLE. Changes during SOUND have no effect.
- `last_index` changes after `start` have no effect until the next `start`.
- Width rules:
  - `note_counter` wraps 15→0 only via `loop`; it never increments past the latched index.
  - Note, gap and tone counters are 32-bit unsigned with no overflow, given the parameter and `freq_in` ranges.

## Timing
- `start` sampled at edge E0 → at E0: `busy`=1, `ld_play`=1, `note_counter`=0.
- Datapath captures the address at E1; memory q is valid after E2; `freq_in` is stable for the sample at E3.
- `period` is latched at edge E0+`SETTLE_CYCLES`. SOUND begins the same cycle.
- First `audio_out` toggle comes `period` cycles after SOUND entry.
- Per-note duration: `SETTLE_CYCLES`+`NOTE_TICKS`+`GAP_TICKS` cycles.
- Full sequence, no loop: (latched index+1)×that duration. `done` asserts in the cycle after the final GAP cycle; `busy` falls on that same edge.
- `stop` latency: 1 cycle to IDLE and `audio_out`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Use parameters NOTE_TICKS=8, GAP_TICKS=2, SETTLE=3.
- Reset mid-SOUND with `audio_out`=1 → all outputs 0 immediately (asynchronous). After release, stays IDLE until `start`.
- `last_index`=2, `freq_in`=2 constant, `start` → `note_counter` reads 0,1,2 across three 13-cycle notes. `audio_out` toggles every 2 cycles in SOUND and is 0 in SETTLE/GAP. `done` pulses once at cycle 39; `busy` drops then.
- `freq_in`=0 for note 1 → `audio_out` stays 0 throughout that SOUND; the neighbouring notes still toggle.
- `loop`=1, `last_index`=1 → sequence 0,1,0,1… with no `done`. Deassert `loop` during note 1 → ends after that note's GAP with `done`.
- `stop` on the 4th SOUND cycle → IDLE next edge, `audio_out`=0, `note_counter`=0, no `done`. A `start` pulse mid-play is ignored, and `note_counter` keeps its sequence.
- `last_index`=15 → plays 16 notes, 0..15, then `done`. A `last_index` change after `start` has no effect.

Source files
------------

// File: rtl/playback_sequencer_if.sv
// Control/status bundle between the playback sequencer and its note datapath.
// master = controller/datapath side, slave = sequencer side.
interface playback_sequencer_if;
  logic        start;
  logic        stop;
  logic        loop;
  logic [3:0]  last_index;
  logic [31:0] freq_in;
  logic        ld_play;
  logic [3:0]  note_counter;
  logic        busy;
  logic        done;
  logic        audio_out;

  modport master (
    output start, stop, loop, last_index, freq_in,
    input  ld_play, note_counter, busy, done, audio_out
  );

  modport slave (
    input  start, stop, loop, last_index, freq_in,
    output ld_play, note_counter, busy, done, audio_out
  );
endinterface

// File: rtl/playback_sequencer.sv
// Steps through recorded notes, waits for the datapath read to settle, then
// sounds each note as a square wave followed by a silent gap.
module playback_sequencer #(
  parameter int unsigned NOTE_TICKS    = 25_000_000,
  parameter int unsigned GAP_TICKS     = 2_500_000,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  playback_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SOUND, GAP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  note_counter_q, note_counter_d;
  logic [3:0]  last_idx_q, last_idx_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] tone_q, tone_d;
  logic [31:0] period_q, period_d;
  logic        audio_q, audio_d;
  logic        done_q, done_d;

  // One phase counter serves as settle, note and gap counter: the states are exclusive.
  always_comb begin
    state_d        = state_q;
    note_counter_d = note_counter_q;
    last_idx_d     = last_idx_q;
    phase_d        = phase_q;
    tone_d         = tone_q;
    period_d       = period_q;
    audio_d        = audio_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d        = SETTLE;
          note_counter_d = '0;
          last_idx_d     = bus.last_index;
          phase_d        = '0;
        end
      end
      SETTLE: begin
        if (phase_q == SETTLE_CYCLES - 1) begin
          period_d = bus.freq_in;
          tone_d   = '0;
          phase_d  = '0;
          audio_d  = 1'b0;
          state_d  = SOUND;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      SOUND: begin
        if (period_q != '0) begin
          if (tone_q == period_q - 32'd1) begin
            tone_d  = '0;
            audio_d = ~audio_q;
          end else begin
            tone_d = tone_q + 32'd1;
          end
        end
        if (phase_q == NOTE_TICKS - 1) begin
          state_d = GAP;
          audio_d = 1'b0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      GAP: begin
        if (phase_q == GAP_TICKS - 1) begin
          phase_d = '0;
          if (note_counter_q < last_idx_q) begin
            note_counter_d = note_counter_q + 4'd1;
            state_d        = SETTLE;
          end else if (bus.loop) begin
            note_counter_d = '0;
            state_d        = SETTLE;
          end else begin
            note_counter_d = '0;
            done_d         = 1'b1;
            state_d        = IDLE;
          end
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever transition the state logic chose this cycle.
    if (bus.stop && state_q != IDLE) begin
      state_d        = IDLE;
      note_counter_d = '0;
      audio_d        = 1'b0;
      done_d         = 1'b0;
      phase_d        = '0;
      tone_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      note_counter_q <= '0;
      last_idx_q     <= '0;
      phase_q        <= '0;
      tone_q         <= '0;
      period_q       <= '0;
      audio_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      note_counter_q <= note_counter_d;
      last_idx_q     <= last_idx_d;
      phase_q        <= phase_d;
      tone_q         <= tone_d;
      period_q       <= period_d;
      audio_q        <= audio_d;
      done_q         <= done_d;
    end
  end

  assign bus.ld_play      = (state_q != IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.note_counter = note_counter_q;
  assign bus.done         = done_q;
  assign bus.audio_out    = audio_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: a two-register note memory feeds freq_in and a
// per-cycle expectation list is built from note/gap/tone timing arithmetic.
module tb_playback_sequencer;
  localparam int unsigned NT = 8;
  localparam int unsigned GT = 2;
  localparam int unsigned ST = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playback_sequencer_if pif();

  playback_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .SETTLE_CYCLES(ST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  // Datapath: address register then registered memory output.
  logic [31:0] mem [16];
  logic [3:0]  addr_q;
  always @(posedge clk) begin
    addr_q      <= pif.note_counter;
    pif.freq_in <= mem[addr_q];
  end

  typedef struct {
    logic [3:0] nc;
    logic       busy;
    logic       done;
    logic       audio;
    int         tick;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".note_counter"}, {28'd0, pif.note_counter}, {28'd0, e.nc});
    chk({tag, ".busy"},    {31'd0, pif.busy},      {31'd0, e.busy});
    chk({tag, ".ld_play"}, {31'd0, pif.ld_play},   {31'd0, e.busy});
    chk({tag, ".done"},    {31'd0, pif.done},      {31'd0, e.done});
    chk({tag, ".audio"},   {31'd0, pif.audio_out}, {31'd0, e.audio});
  endtask

  // Plays the given note order; per-note time is settle + sound + gap cycles.
  task automatic run(input string tag, input int notes[$], input int li,
                     input int loop_drop, input int stop_at, input int kick_at,
                     input bit stop_with_start, input bit mutate);
    exp_t eq[$];
    exp_t e;
    int   p;
    for (int k = 0; k < notes.size(); k++) begin
      p = int'(mem[notes[k]]);
      for (int t = 0; t < int'(ST); t++) begin
        e = '{4'(notes[k]), 1'b1, 1'b0, 1'b0, -1}; eq.push_back(e);
      end
      for (int t = 0; t < int'(NT); t++) begin
        e = '{4'(notes[k]), 1'b1, 1'b0, (p == 0) ? 1'b0 : 1'((t / p) % 2), t};
        eq.push_back(e);
      end
      for (int t = 0; t < int'(GT); t++) begin
        e = '{4'(notes[k]), 1'b1, 1'b0, 1'b0, -1}; eq.push_back(e);
      end
    end
    e = '{4'd0, 1'b0, 1'b1, 1'b0, -1}; eq.push_back(e);
    e = '{4'd0, 1'b0, 1'b0, 1'b0, -1}; eq.push_back(e); eq.push_back(e);
    if (stop_at >= 0) begin
      while (eq.size() > stop_at + 1) void'(eq.pop_back());
      e = '{4'd0, 1'b0, 1'b0, 1'b0, -1};
      eq.push_back(e); eq.push_back(e); eq.push_back(e);
    end

    pif.last_index = 4'(li);
    pif.start      = 1'b1;
    pif.stop       = stop_with_start;
    step();
    pif.start = 1'b0;
    pif.stop  = 1'b0;
    for (int i = 0; i < eq.size(); i++) begin
      chk_all($sformatf("%s[%0d]", tag, i), eq[i]);
      pif.stop       = (i == stop_at);
      pif.start      = (i == kick_at);
      pif.last_index = 4'($urandom);
      if (i == loop_drop) pif.loop = 1'b0;
      if (mutate && eq[i].tick == 4) mem[eq[i].nc] = $urandom_range(0, 5);
      step();
    end
    pif.stop  = 1'b0;
    pif.start = 1'b0;
    pif.loop  = 1'b0;
  endtask

  initial begin
    int   nq[$];
    int   li;
    exp_t idle;
    idle = '{4'd0, 1'b0, 1'b0, 1'b0, -1};

    reset = 1'b0;
    pif.start = 1'b0; pif.stop = 1'b0; pif.loop = 1'b0; pif.last_index = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd2;
    step(); step();
    chk_all("reset", idle);
    reset = 1'b1;
    step();
    chk_all("post_reset", idle);

    // Three notes at half-period 2; done lands 39 cycles after start.
    nq.delete(); for (int i = 0; i <= 2; i++) nq.push_back(i);
    run("basic", nq, 2, -1, -1, -1, 1'b0, 1'b0);

    // Rest in the middle note.
    mem[0] = 32'd3; mem[1] = 32'd0; mem[2] = 32'd2;
    run("rest", nq, 2, -1, -1, -1, 1'b0, 1'b0);

    // Loop 0,1,0,1 then drop loop during the fourth note.
    mem[0] = 32'd2; mem[1] = 32'd3;
    nq.delete(); nq.push_back(0); nq.push_back(1); nq.push_back(0); nq.push_back(1);
    pif.loop = 1'b1;
    run("loop", nq, 1, 44, -1, -1, 1'b0, 1'b0);

    // Abort on the fourth SOUND cycle of note 0; start+stop together in IDLE starts.
    nq.delete(); for (int i = 0; i <= 2; i++) nq.push_back(i);
    run("stop", nq, 2, -1, 6, -1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_all($sformatf("stop_idle[%0d]", i), idle);
      step();
    end

    // start pulse mid-play is ignored.
    run("kick", nq, 2, -1, -1, 17, 1'b0, 1'b0);

    // All 16 notes, random tones, freq_in disturbed mid-SOUND.
    for (int i = 0; i < 16; i++) mem[i] = $urandom_range(0, 4);
    nq.delete(); for (int i = 0; i <= 15; i++) nq.push_back(i);
    run("full16", nq, 15, -1, -1, -1, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom_range(0, 5);
      li = $urandom_range(0, 5);
      nq.delete(); for (int i = 0; i <= li; i++) nq.push_back(i);
      run($sformatf("rand%0d", r), nq, li, -1, -1, -1, 1'b0, 1'b1);
    end

    // Asynchronous reset while audio_out is high.
    mem[0] = 32'd1;
    pif.last_index = 4'd0;
    pif.start = 1'b1;
    step();
    pif.start = 1'b0;
    step(); step(); step(); step();
    chk("mid_sound.audio", {31'd0, pif.audio_out}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_all("async_reset", idle);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all($sformatf("after_reset[%0d]", i), idle);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
